// File: rtl/kp_voice_alloc_if.sv
// rtl/kp_voice_alloc_if.sv - note event handshake between the event front end and the voice allocator
interface kp_voice_alloc_if #(
  parameter int LEN_W = 16
);
  logic             ev_valid;
  logic             ev_ready;
  logic             ev_on;
  logic [6:0]       ev_note;
  logic [6:0]       ev_vel;
  logic [LEN_W-1:0] ev_len;

  modport master (output ev_valid, ev_on, ev_note, ev_vel, ev_len, input ev_ready);
  modport slave  (input ev_valid, ev_on, ev_note, ev_vel, ev_len, output ev_ready);
endinterface

// File: rtl/kp_voice_alloc.sv
// rtl/kp_voice_alloc.sv - polyphonic voice allocator driving trig/length/velocity of a KP voice bank
module kp_voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int LEN_W      = 16,
  parameter int AGE_W      = 8,
  parameter int TRIG_HOLD  = 8,
  parameter int TRIG_GAP   = 8
) (
  input  logic                        audio_clk,
  input  logic                        reset_n,
  kp_voice_alloc_if.slave             ev,
  output logic [NUM_VOICES-1:0]       voice_trig,
  output logic [NUM_VOICES*LEN_W-1:0] voice_len,
  output logic [NUM_VOICES*7-1:0]     voice_vel,
  output logic [NUM_VOICES-1:0]       voice_active,
  output logic                        steal_pulse
);
  localparam int IDX_W   = $clog2(NUM_VOICES);
  localparam int CNT_MAX = (TRIG_HOLD > TRIG_GAP) ? TRIG_HOLD : TRIG_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;
  typedef enum logic [1:0] {T_IDLE, T_HOLD, T_GAP} trig_t;

  state_t           state;
  logic             ready;
  logic [IDX_W-1:0] scan_idx;
  logic             lat_on;
  logic [6:0]       lat_note;
  logic [6:0]       lat_vel;
  logic [LEN_W-1:0] lat_len;
  logic             found_same, found_free, have_old;
  logic [IDX_W-1:0] same_idx, free_idx, old_idx;
  logic [AGE_W-1:0] old_age;
  logic [6:0]       note [NUM_VOICES];
  logic [AGE_W-1:0] age  [NUM_VOICES];
  trig_t            tst  [NUM_VOICES];
  logic [CNT_W-1:0] tcnt [NUM_VOICES];
  logic [IDX_W-1:0] tgt;
  logic             tgt_ok, do_steal;

  function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
    return (a == '1) ? a : a + 1'b1;
  endfunction

  assign ev.ev_ready = ready;

  always_comb begin
    tgt      = same_idx;
    tgt_ok   = found_same;
    do_steal = 1'b0;
    if (lat_on && !found_same) begin
      tgt_ok = 1'b1;
      if (found_free) begin
        tgt = free_idx;
      end else begin
        tgt      = old_idx;
        do_steal = 1'b1;
      end
    end
  end

  always_ff @(posedge audio_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      ready        <= 1'b0;
      scan_idx     <= '0;
      lat_on       <= 1'b0;
      lat_note     <= '0;
      lat_vel      <= '0;
      lat_len      <= '0;
      found_same   <= 1'b0;
      found_free   <= 1'b0;
      have_old     <= 1'b0;
      same_idx     <= '0;
      free_idx     <= '0;
      old_idx      <= '0;
      old_age      <= '0;
      voice_trig   <= '0;
      voice_len    <= '0;
      voice_vel    <= '0;
      voice_active <= '0;
      steal_pulse  <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note[i] <= '0;
        age[i]  <= '0;
        tst[i]  <= T_IDLE;
        tcnt[i] <= '0;
      end
    end else begin
      steal_pulse <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (voice_active[i]) age[i] <= sat_inc(age[i]);
        case (tst[i])
          T_HOLD: begin
            if (tcnt[i] == '0) begin
              tst[i]        <= T_GAP;
              tcnt[i]       <= CNT_W'(TRIG_GAP - 1);
              voice_trig[i] <= 1'b0;
            end else begin
              tcnt[i] <= tcnt[i] - 1'b1;
            end
          end
          T_GAP: begin
            if (tcnt[i] == '0) tst[i] <= T_IDLE;
            else               tcnt[i] <= tcnt[i] - 1'b1;
          end
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (ready && ev.ev_valid) begin
            ready      <= 1'b0;
            state      <= S_SCAN;
            scan_idx   <= '0;
            lat_on     <= ev.ev_on && (ev.ev_vel != 7'd0);
            lat_note   <= ev.ev_note;
            lat_vel    <= ev.ev_vel;
            lat_len    <= ev.ev_len;
            found_same <= 1'b0;
            found_free <= 1'b0;
            have_old   <= 1'b0;
          end else begin
            ready <= 1'b1;
          end
        end
        S_SCAN: begin
          // old_age follows the chosen voice's own aging so later voices compare against its live age
          old_age <= sat_inc(old_age);
          if (voice_active[scan_idx]) begin
            if (!found_same && note[scan_idx] == lat_note) begin
              found_same <= 1'b1;
              same_idx   <= scan_idx;
            end
            if (!have_old || age[scan_idx] > old_age) begin
              have_old <= 1'b1;
              old_idx  <= scan_idx;
              old_age  <= sat_inc(age[scan_idx]);
            end
          end else if (!found_free) begin
            found_free <= 1'b1;
            free_idx   <= scan_idx;
          end
          if (scan_idx == LAST_IDX) state <= S_COMMIT;
          else                      scan_idx <= scan_idx + 1'b1;
        end
        S_COMMIT: begin
          if (!tgt_ok) begin
            state <= S_IDLE;
            ready <= 1'b1;
          end else if (!lat_on) begin
            voice_active[tgt] <= 1'b0;
            state             <= S_IDLE;
            ready             <= 1'b1;
          end else if (tst[tgt] == T_IDLE) begin
            note[tgt]                          <= lat_note;
            voice_len[int'(tgt)*LEN_W +: LEN_W] <= lat_len;
            voice_vel[int'(tgt)*7 +: 7]         <= lat_vel;
            voice_active[tgt]                  <= 1'b1;
            age[tgt]                           <= '0;
            tst[tgt]                           <= T_HOLD;
            tcnt[tgt]                          <= CNT_W'(TRIG_HOLD - 1);
            voice_trig[tgt]                    <= 1'b1;
            steal_pulse                        <= do_steal;
            state                              <= S_IDLE;
            ready                              <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_kp_voice_alloc.sv
// tb/tb_kp_voice_alloc.sv - self-checking bench for kp_voice_alloc against a timeline model of voice allocation
module tb_kp_voice_alloc;
  localparam int N     = 4;
  localparam int LEN_W = 16;
  localparam int AGE_W = 8;
  localparam int H     = 8;
  localparam int G     = 8;
  localparam int NEVER = 1 << 30;

  logic audio_clk = 1'b0;
  logic reset_n   = 1'b1;
  always #5 audio_clk = ~audio_clk;

  kp_voice_alloc_if #(.LEN_W(LEN_W)) ev ();
  logic [N-1:0]       voice_trig;
  logic [N*LEN_W-1:0] voice_len;
  logic [N*7-1:0]     voice_vel;
  logic [N-1:0]       voice_active;
  logic               steal_pulse;

  kp_voice_alloc #(.NUM_VOICES(N), .LEN_W(LEN_W), .AGE_W(AGE_W), .TRIG_HOLD(H), .TRIG_GAP(G)) dut (
    .audio_clk    (audio_clk),
    .reset_n      (reset_n),
    .ev           (ev),
    .voice_trig   (voice_trig),
    .voice_len    (voice_len),
    .voice_vel    (voice_vel),
    .voice_active (voice_active),
    .steal_pulse  (steal_pulse)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 0;
  int steal_seen = 0;
  int trig_seen = 0;

  // model: per-voice note state plus the cycle windows in which outputs must show each effect
  bit m_act [N];
  int m_note [N];
  int m_len [N];
  int m_vel [N];
  int m_start [N];
  int m_rise [N];
  int m_rdy_from, m_busy_from, m_busy_to, m_steal_at;
  bit p_valid, p_on, p_steal;
  int p_at, p_tgt, p_note, p_len, p_vel;

  always @(posedge audio_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_note[i] = 0; m_len[i] = 0; m_vel[i] = 0;
      m_start[i] = 0; m_rise[i] = -1000;
    end
    m_rdy_from = NEVER; m_busy_from = NEVER; m_busy_to = NEVER;
    m_steal_at = -1; p_valid = 0;
  endfunction

  function automatic void apply_pending();
    if (p_valid && cyc >= p_at) begin
      p_valid = 0;
      if (p_on) begin
        m_act[p_tgt] = 1; m_note[p_tgt] = p_note; m_len[p_tgt] = p_len; m_vel[p_tgt] = p_vel;
        m_start[p_tgt] = p_at; m_rise[p_tgt] = p_at;
        if (p_steal) m_steal_at = p_at;
      end else begin
        m_act[p_tgt] = 0;
      end
    end
  endfunction

  function automatic void model_event(input bit on, input int note, input int vel, input int len, input int a);
    bit is_on;
    int tgt, best, p, ag;
    bit steal;
    apply_pending();
    is_on = on && (vel != 0);
    tgt = -1; steal = 0; best = -1;
    for (int i = 0; i < N; i++)
      if (tgt < 0 && m_act[i] && m_note[i] == note) tgt = i;
    if (is_on && tgt < 0)
      for (int i = 0; i < N; i++)
        if (tgt < 0 && !m_act[i]) tgt = i;
    if (is_on && tgt < 0) begin
      for (int i = 0; i < N; i++) begin
        ag = a + 1 - m_start[i];
        if (ag > 255) ag = 255;
        if (ag > best) begin best = ag; tgt = i; end
      end
      steal = 1;
    end
    p = a + N + 1;
    if (is_on && m_rise[tgt] + H + G > p) p = m_rise[tgt] + H + G;
    m_busy_from = a + 1;
    m_busy_to   = p + 1;
    if (tgt >= 0) begin
      p_valid = 1; p_at = p + 1; p_on = is_on; p_tgt = tgt;
      p_note = note; p_len = len; p_vel = vel; p_steal = steal;
    end
  endfunction

  always @(negedge audio_clk) begin
    if (chk_en) begin
      logic [N-1:0] e_trig, e_act;
      logic [N*LEN_W-1:0] e_len;
      logic [N*7-1:0] e_vel;
      logic e_ready;
      apply_pending();
      for (int i = 0; i < N; i++) begin
        e_trig[i] = (cyc >= m_rise[i]) && (cyc < m_rise[i] + H);
        e_act[i] = m_act[i];
        e_len[i*LEN_W +: LEN_W] = LEN_W'(m_len[i]);
        e_vel[i*7 +: 7] = 7'(m_vel[i]);
      end
      e_ready = (cyc >= m_rdy_from) && !(cyc >= m_busy_from && cyc < m_busy_to);
      check("voice_trig", voice_trig, e_trig);
      check("voice_active", voice_active, e_act);
      check("voice_len", voice_len, e_len);
      check("voice_vel", voice_vel, e_vel);
      check("ev_ready", ev.ev_ready, e_ready);
      check("steal_pulse", steal_pulse, cyc == m_steal_at);
      if (steal_pulse) steal_seen++;
      if (voice_trig != '0) trig_seen++;
    end
  end

  task automatic step();
    @(posedge audio_clk);
    #1;
  endtask

  task automatic do_reset();
    ev.ev_valid = 0;
    reset_n = 0;
    model_reset();
    step();
    step();
    reset_n = 1;
    m_rdy_from = cyc + 1;
  endtask

  task automatic send(input bit on, input int note, input int vel, input int len, output int acc);
    int waited = 0;
    while (ev.ev_ready !== 1'b1 && waited < 200) begin
      step();
      waited++;
    end
    if (ev.ev_ready !== 1'b1) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout cyc=%0d actual=0 expected=1", cyc);
      acc = -1;
      return;
    end
    ev.ev_valid = 1; ev.ev_on = on;
    ev.ev_note = 7'(note); ev.ev_vel = 7'(vel); ev.ev_len = LEN_W'(len);
    acc = cyc;
    model_event(on, note, vel, len, acc);
    step();
    ev.ev_valid = 0; ev.ev_on = 1'($urandom);
    ev.ev_note = 7'($urandom); ev.ev_vel = 7'($urandom); ev.ev_len = LEN_W'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1);
  end

  initial begin
    int a, a2, rise, rise2, highs, fall, s0, t0;
    ev.ev_valid = 0; ev.ev_on = 0; ev.ev_note = 0; ev.ev_vel = 0; ev.ev_len = 0;
    #1;
    do_reset();
    chk_en = 1;
    check("reset_ready_low", ev.ev_ready, 0);
    check("reset_outputs", {voice_trig, voice_active, voice_len, voice_vel, steal_pulse}, 0);
    step();
    check("ready_after_reset", ev.ev_ready, 1);

    // T1: single note-on, trigger timing
    s0 = steal_seen;
    send(1, 60, 100, 200, a);
    rise = -1; highs = 0;
    repeat (40) begin
      if (voice_trig[0]) begin
        if (rise < 0) rise = cyc - a;
        highs++;
      end
      step();
    end
    check("t1_trig_rise", rise, 6);
    check("t1_trig_width", highs, 8);
    check("t1_len", voice_len[15:0], 200);
    check("t1_vel", voice_vel[6:0], 100);
    check("t1_active", voice_active, 4'b0001);
    check("t1_no_steal", steal_seen - s0, 0);

    // T2: fill all voices, fifth note steals the oldest
    do_reset();
    send(1, 60, 10, 100, a);
    send(1, 62, 11, 101, a);
    send(1, 64, 12, 102, a);
    send(1, 65, 13, 103, a);
    s0 = steal_seen;
    send(1, 67, 77, 999, a);
    repeat (12) step();
    check("t2_steal_count", steal_seen - s0, 1);
    check("t2_len_all", voice_len, 64'h0067_0066_0065_03E7);
    check("t2_vel0", voice_vel[6:0], 77);
    check("t2_active", voice_active, 4'b1111);

    // T3: note-off keeps len/vel; unmatched note-off changes nothing
    do_reset();
    send(1, 60, 50, 200, a);
    send(0, 60, 0, 555, a);
    repeat (10) step();
    check("t3_off_active", voice_active, 4'b0000);
    check("t3_off_len", voice_len[15:0], 200);
    check("t3_off_vel", voice_vel[6:0], 50);
    send(0, 61, 0, 0, a);
    repeat (10) step();
    check("t3_drop_active", voice_active, 4'b0000);
    check("t3_drop_len", voice_len[15:0], 200);

    // T4: retrigger issued inside the gap waits for the gap to finish
    do_reset();
    send(1, 60, 100, 300, a);
    t0 = 0;
    while (voice_trig[0] !== 1'b1 && t0 < 50) begin step(); t0++; end
    rise = cyc;
    while (voice_trig[0] === 1'b1 && t0 < 50) begin step(); t0++; end
    fall = cyc;
    send(1, 60, 101, 301, a2);
    t0 = 0;
    while (voice_trig[0] !== 1'b1 && t0 < 50) begin step(); t0++; end
    rise2 = cyc;
    check("t4_retrig_spacing", rise2 - rise, 17);
    check("t4_gap_ge8", (rise2 - fall) >= 8, 1);
    check("t4_one_voice", voice_active, 4'b0001);
    check("t4_len", voice_len[15:0], 301);
    repeat (20) step();

    // T5: note-on with velocity 0 releases the sounding note
    do_reset();
    send(1, 60, 90, 400, a);
    send(1, 60, 0, 7, a);
    repeat (10) step();
    check("t5_active", voice_active, 4'b0000);
    check("t5_vel_kept", voice_vel[6:0], 90);
    check("t5_len_kept", voice_len[15:0], 400);

    // T6: reset during SCAN clears everything and the event is lost
    do_reset();
    send(1, 50, 33, 123, a);
    repeat (20) step();
    send(1, 60, 100, 200, a);
    step();
    reset_n = 0;
    model_reset();
    #1;
    check("t6_cleared", {voice_trig, voice_active, voice_len, voice_vel, steal_pulse}, 0);
    check("t6_ready_low", ev.ev_ready, 0);
    step();
    step();
    reset_n = 1;
    m_rdy_from = cyc + 1;
    s0 = trig_seen;
    repeat (20) step();
    check("t6_no_trig", trig_seen - s0, 0);
    check("t6_ready", ev.ev_ready, 1);
    check("t6_active", voice_active, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
